// File: rtl/wide_add_seq_pkg.sv
// Shared types and helpers for the word-serial wide adder.
package wide_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index register must stay at least one bit wide even when WORDS == 1.
  function automatic int idx_width(input int words);
    int w;
    w = $clog2(words);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_ripple.sv
// Narrow ripple-carry adder shared by every word of the wide addition.
module RippleAdder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] c,
  output logic             carry_out,
  output logic             overflow
);

  logic [WIDTH:0] w_cy;

  always_comb begin
    w_cy    = '0;
    c       = '0;
    w_cy[0] = carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      c[i]      = a[i] ^ b[i] ^ w_cy[i];
      w_cy[i+1] = (a[i] & b[i]) | (w_cy[i] & (a[i] ^ b[i]));
    end
  end

  assign carry_out = w_cy[WIDTH];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow  = w_cy[WIDTH] ^ w_cy[WIDTH-1];

endmodule

// File: rtl/wide_add_sequencer.sv
// Computes a WORDS*WIDTH-bit sum one word per cycle through a single narrow
// adder, LSW first, with valid/ready handshakes on both sides.
module wide_add_sequencer
  import wide_add_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   carry_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   carry_out,
  output logic                   overflow
);

  localparam int                IDX_W    = idx_width(WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [IDX_W-1:0]       r_idx;
  logic [WIDTH*WORDS-1:0] r_a;
  logic [WIDTH*WORDS-1:0] r_b;
  logic                   r_carry;
  logic [WIDTH*WORDS-1:0] r_sum;
  logic                   r_carry_out;
  logic                   r_overflow;
  logic                   r_out_valid;

  logic [WIDTH-1:0]       w_a_word;
  logic [WIDTH-1:0]       w_b_word;
  logic [WIDTH-1:0]       w_c;
  logic                   w_co;
  logic                   w_ov;
  logic                   w_last;

  always_comb begin
    w_a_word = r_a[int'(r_idx)*WIDTH +: WIDTH];
    w_b_word = r_b[int'(r_idx)*WIDTH +: WIDTH];
  end

  assign w_last = (r_idx == LAST_IDX);

  RippleAdder #(.WIDTH(WIDTH)) u_adder (
    .a         (w_a_word),
    .b         (w_b_word),
    .carry_in  (r_carry),
    .c         (w_c),
    .carry_out (w_co),
    .overflow  (w_ov)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = RUN;
      RUN:     if (w_last)   w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= carry_in;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[int'(r_idx)*WIDTH +: WIDTH] <= w_c;
          r_carry <= w_co;
          if (w_last) begin
            r_carry_out <= w_co;
            r_overflow  <= w_ov;
            r_out_valid <= 1'b1;
            r_idx       <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (WIDTH=8, WORDS=4) using a
// scoreboard queue of expected results.
module tb_wide_add_sequencer;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  typedef struct packed {
    logic [N-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];

  wide_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
    exp_t        e;
    logic [N:0]  full;
    full = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
    e.s  = full[N-1:0];
    e.co = full[N];
    e.ov = (x[N-1] == y[N-1]) && (e.s[N-1] != x[N-1]);
    return e;
  endfunction

  // Present operands and wait for the accepting edge; returns at the negedge after it.
  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_total++;
    if (!in_ready) begin
      $display("FAIL send_timeout: in_ready got %0b expected 1", in_ready);
      return;
    end
    n_pass++;
    a = x; b = y; carry_in = ci; in_valid = 1'b1;
    sb.push_back(model(x, y, ci));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input bit hold_ready, output int waited);
    exp_t e;
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (!out_valid || sb.size() == 0) begin
      $display("FAIL recv_timeout: out_valid got %0b queue %0d expected result", out_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    if ({sum, carry_out, overflow} !== {e.s, e.co, e.ov})
      $display("FAIL result: got sum=%h co=%0b ov=%0b expected sum=%h co=%0b ov=%0b",
               sum, carry_out, overflow, e.s, e.co, e.ov);
    else n_pass++;
    if (!hold_ready) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_total++;
      if ({sum, carry_out, overflow, out_valid, in_ready} !== '0)
        $display("FAIL reset_outputs: got sum=%h co=%0b ov=%0b ov_valid=%0b in_ready=%0b expected all 0",
                 sum, carry_out, overflow, out_valid, in_ready);
      else n_pass++;
    end
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: got in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_carry_latency();
    int w;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    // Already one negedge past the accepting edge; valid should show after 4 more.
    recv(1'b0, w);
    n_total++;
    if (w != 4) $display("FAIL latency: got %0d cycles expected 4", w);
    else n_pass++;
    send(32'h0, 32'h0, 1'b1);
    recv(1'b0, w);
  endtask

  task automatic test_ripple_overflow();
    int w;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    recv(1'b0, w);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    recv(1'b0, w);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    recv(1'b0, w);
    for (int i = 0; i < 4; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
      recv(1'b0, w);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send($urandom, $urandom, 1'(i & 1));
      recv(1'b1, w);
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL done_one_cycle: got out_valid=%0b in_ready=%0b expected 0/1", out_valid, in_ready);
      else n_pass++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   t;
    int   bad;
    int   w;
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    e = sb[0];
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; carry_in = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {sum, carry_out, overflow} !== {e.s, e.co, e.ov})
        bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL backpressure_hold: got %0d bad cycles expected 0", bad);
    else n_pass++;
    a = 32'h0000_0010; b = 32'h0000_0020; carry_in = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL backpressure_release: got in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
    else n_pass++;
    void'(sb.pop_front());
    send(32'h0000_0010, 32'h0000_0020, 1'b0);
    recv(1'b0, w);
  endtask

  task automatic test_reset_mid_run();
    int seen;
    int w;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; carry_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b expected 0", in_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if ({sum, carry_out, overflow, out_valid} !== '0 || in_ready !== 1'b1)
      $display("FAIL abort_clear: got sum=%h co=%0b ov=%0b out_valid=%0b in_ready=%0b expected 0s and in_ready 1",
               sum, carry_out, overflow, out_valid, in_ready);
    else n_pass++;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen);
    else n_pass++;
    send(32'h0000_0002, 32'h0000_0003, 1'b0);
    n_total++;
    if (sb[sb.size()-1].s !== 32'h0000_0005)
      $display("FAIL model_sanity: got %h expected 00000005", sb[sb.size()-1].s);
    else n_pass++;
    recv(1'b0, w);
  endtask

  initial begin
    test_reset();
    test_carry_latency();
    test_ripple_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-cycle controller that computes a WORDS*WIDTH-bit sum using one shared WIDTH-bit RippleAdder. It processes one word per cycle, least-significant word first, and chains the carry through a register. It sits between a valid/ready producer and a valid/ready consumer. It trades latency for area when wide additions are needed but only a narrow adder is affordable.

Parameters:
WIDTH, 8, width of the shared adder and of one operand word
WORDS, 4, number of words per operand; must be >= 1 (total operand width = WIDTH*WORDS)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  producer has operands on a, b, carry_in
in_ready  out  1  sequencer can accept operands
a  in  WIDTH*WORDS  operand A, word 0 = bits [WIDTH-1:0]
b  in  WIDTH*WORDS  operand B
carry_in  in  1  carry into word 0
out_valid  out  1  sum, carry_out and overflow are valid
out_ready  in  1  consumer accepts the result
sum  out  WIDTH*WORDS  registered full-width sum
carry_out  out  1  carry out of the top word
overflow  out  1  two's-complement overflow of the full-width add (taken from the top-word add)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high at a rising edge:
  - state goes to IDLE and the word index to 0
  - operand registers, carry register, sum, carry_out and overflow go to 0
  - out_valid goes to 0
  - in_ready is 0 while rst is high
- States (shared enum): IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: latch a, b, carry_in into internal registers, set index to 0, go to RUN.
  - in_valid while not in IDLE is ignored (no capture).
- RUN:
  - in_ready = 0.
  - The adder is fed word[index] of A and B plus the carry register.
  - Each edge:
    - sum word[index] <= adder c
    - carry register <= adder carry_out
    - index++
  - When index == WORDS-1 at the edge:
    - carry_out <= adder carry_out
    - overflow <= adder overflow
    - go to DONE
- DONE:
  - out_valid = 1 (registered).
  - sum, carry_out and overflow are held stable.
  - On out_ready at an edge: out_valid <= 0, go to IDLE.
  - With out_ready held high, DONE lasts exactly one cycle. A new operand set is accepted no earlier than the first IDLE cycle.
- Latency: out_valid rises WORDS edges after the accepting edge. Throughput is one operation per WORDS+2 cycles with out_ready held high.
- WORDS=1: a single RUN cycle. The index register is at least 1 bit wide.
- Width rules:
  - Wrap-around is modulo 2^(WIDTH*WORDS); the carry is reported only on carry_out.
  - overflow refers to the signed interpretation of the full-width operands.
- Reset mid-operation (RUN or DONE): the operation is aborted, no out_valid is produced, and all outputs clear as above.
- Simultaneous events:
  - rst has priority over every handshake.
  - In DONE, in_valid is ignored even if out_ready is high in the same cycle.
- The sum register is updated only during RUN. Sum words from a previous result remain until overwritten; the consumer samples only with out_valid.

Decomposition:
- Package wide_add_seq_pkg:
  - state_t enum {IDLE, RUN, DONE}
  - helper constant function for index width: max(1, clog2(WORDS))
- The single sub-module is the existing RippleAdder #(WIDTH), instantiated once with ports a, b, carry_in, c, carry_out, overflow.
- The controller FSM, index counter and word mux/demux live in wide_add_sequencer.

Test Plan:
All scenarios use WIDTH=8, WORDS=4.
1. Reset and idle: assert rst 2 cycles, then release -> sum=0, carry_out=0, overflow=0 and out_valid=0 during reset; in_ready=0 while rst high, 1 in the first cycle after.
2. Carry between words and latency: a=0x000000FF, b=0x00000001, carry_in=0, accepted at edge E -> out_valid first high after edge E+4; sum=0x00000100, carry_out=0, overflow=0. Also a=0, b=0, carry_in=1 -> sum=0x00000001.
3. Full ripple: a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, carry_out=1, overflow=0.
4. Signed overflow: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, carry_out=0, overflow=1. Also a=0x80000000, b=0x80000000 -> sum=0, carry_out=1, overflow=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> sum/flags stable, in_ready=0, new operands not captured. Raise out_ready -> IDLE next cycle, then the new operand set is accepted.
6. Reset mid-RUN: assert rst on the 2nd RUN cycle for 1 cycle -> next cycle IDLE, outputs 0, no out_valid pulse ever appears for the aborted operation. A following add of 0x00000002+0x00000003 yields sum=0x00000005.
